audio_frame_sequencer: RTL and testbench
========================================

// Module: audio_frame_sequencer
// PURPOSE
// - Sequences the codec streaming path per stereo frame: collects one L and one R ADC sample,
//   hands the pair to a user DSP stage via start/done, then delivers both results to the DAC sinks.
// - Sits between the audio codec Avalon-ST ports and effect RTL; replaces the free-running ADC->DAC tie-back.
// - Provides mute, bypass and a DSP watchdog. On timeout the dry samples are passed through.
// PARAMETERS
// - DW       24    sample width, matching the codec stream data width
// - TMO_CYC  4096  clk cycles allowed from dsp_start to dsp_done; must be >= 2
// - CNT_W    16    width of the stats counters (AUDIO_SEQ_STATS_EN only)
// PORTS
// - clk         in   1   system clock (CLOCK_50)
// - reset       in   1   synchronous, active-high
// - adc_l_data  in   DW  left ADC stream data;  adc_l_valid in 1; adc_l_ready out 1
// - adc_r_data  in   DW  right ADC stream data; adc_r_valid in 1; adc_r_ready out 1
// - dac_l_data  out  DW  left DAC stream data;  dac_l_valid out 1; dac_l_ready in 1
// - dac_r_data  out  DW  right DAC stream data; dac_r_valid out 1; dac_r_ready in 1
// - dsp_start   out  1   one-cycle pulse: dsp_l_in and dsp_r_in are valid
// - dsp_l_in    out  DW  captured left sample;  dsp_r_in out DW captured right sample
// - dsp_done    in   1   DSP result valid this cycle (single-cycle pulse)
// - dsp_l_out   in   DW  processed left sample;  dsp_r_out in DW processed right sample
// - mute        in   1   level: output zeros, handshakes continue
// - bypass      in   1   level: skip DSP, send captured samples straight to the DAC
// - busy        out  1   high in every state except CAPTURE
// - tmo_err     out  1   one-cycle pulse when the DSP watchdog expires
// BEHAVIOUR
// - Reset state: state=CAPTURE, both holding registers empty, all data outputs 0, all valid/ready 0,
//   dsp_start=0, busy=0, tmo_err=0. The ready outputs rise the cycle after reset deasserts.
// - Reset mid-frame discards all captured and processed samples; no partial frame is ever emitted.
// - CAPTURE:
//   - adc_x_ready=1 while channel x holding reg is empty; transfer when valid&ready.
//   - L and R are independent; both may transfer in the same cycle. A channel already held is not re-accepted.
//   - When both are held, the next state is PROCESS, or OUTPUT if bypass=1 (bypass sampled that cycle).
// - PROCESS:
//   - dsp_start=1 on the first PROCESS cycle only; dsp_l_in/dsp_r_in are held stable throughout PROCESS.
//   - Watchdog counts from 0 at entry. dsp_done is ignored on the first PROCESS cycle (the start cycle).
//   - dsp_done=1: latch dsp_l_out/dsp_r_out and go to OUTPUT.
//   - Count reaches TMO_CYC-1 without done: latch the dry samples, pulse tmo_err, go to OUTPUT.
//   - done and expiry in the same cycle: done wins, no tmo_err.
// - OUTPUT:
//   - Output regs load on entry: zeros if mute=1, else the chosen samples. mute/bypass changes do not affect
//     a frame already in OUTPUT.
//   - Both dac_x_valid=1 from the first OUTPUT cycle.
//   - Each channel drops valid the cycle after its own valid&ready; data is held stable while valid=1.
//   - When both channels have transferred: clear holding regs and return to CAPTURE (ready high next cycle).
// - Both adc_x_ready=0 outside CAPTURE; upstream codec FIFOs absorb the backpressure.
// - Latency, bypass: last ADC transfer at cycle T -> dac valid at T+2.
// - Latency, DSP: last ADC transfer at T -> dsp_start at T+1; dsp_done at cycle D -> dac valid at D+1.
// - Data is passed bit-exact; no arithmetic on samples. Watchdog width is clog2(TMO_CYC) and it saturates.
// CONFIGURATION
// - `AUDIO_SEQ_STATS_EN` defined: adds ports frame_cnt out CNT_W and tmo_cnt out CNT_W.
//   - frame_cnt increments when a frame completes OUTPUT.
//   - tmo_cnt increments on each tmo_err.
//   - Both saturate at all-ones and clear on reset.
// - Undefined: neither port nor their counters exist; all other behaviour is identical.
// TESTING
// - Bypass: L=24'h123456 and R=24'hABCDEF in the same cycle, bypass=1 -> dac_l/r carry the same values
//   at T+2, no dsp_start.
// - Staggered capture: L valid at cycle 5, R valid at cycle 9 -> adc_l_ready=0 during cycles 6-9;
//   dsp_start at cycle 10 only.
// - DSP path: DSP model returns in+1 after 3 cycles -> DAC gets 24'h123457/24'hABCDF0; dsp_start exactly 1 cycle.
// - Watchdog: TMO_CYC=8, no dsp_done -> tmo_err pulse 7 cycles after dsp_start; DAC gets dry samples.
//   With done on the expiry cycle -> no tmo_err.
// - Mute and backpressure: mute=1, dac_r_ready low for 20 cycles -> dac_l transfers 0 at once, dac_r holds 0
//   and valid until ready; next frame only after both transfer.
// - Reset in PROCESS and with STATS_EN: reset mid-frame -> no DAC valid, counters 0;
//   then 3 frames with 1 timeout -> frame_cnt=3, tmo_cnt=1.

Source files
------------

// File: rtl/audio_frame_sequencer_if.sv
// Stream and DSP handshake bundle for audio_frame_sequencer.
// slave is the sequencer side; master is the codec / DSP environment side.
interface audio_frame_sequencer_if #(
    parameter int DW = 24
);
    logic [DW-1:0] adc_l_data;
    logic          adc_l_valid;
    logic          adc_l_ready;
    logic [DW-1:0] adc_r_data;
    logic          adc_r_valid;
    logic          adc_r_ready;

    logic [DW-1:0] dac_l_data;
    logic          dac_l_valid;
    logic          dac_l_ready;
    logic [DW-1:0] dac_r_data;
    logic          dac_r_valid;
    logic          dac_r_ready;

    logic          dsp_start;
    logic [DW-1:0] dsp_l_in;
    logic [DW-1:0] dsp_r_in;
    logic          dsp_done;
    logic [DW-1:0] dsp_l_out;
    logic [DW-1:0] dsp_r_out;

    modport slave (
        input  adc_l_data, adc_l_valid, adc_r_data, adc_r_valid,
        output adc_l_ready, adc_r_ready,
        output dac_l_data, dac_l_valid, dac_r_data, dac_r_valid,
        input  dac_l_ready, dac_r_ready,
        output dsp_start, dsp_l_in, dsp_r_in,
        input  dsp_done, dsp_l_out, dsp_r_out
    );

    modport master (
        output adc_l_data, adc_l_valid, adc_r_data, adc_r_valid,
        input  adc_l_ready, adc_r_ready,
        input  dac_l_data, dac_l_valid, dac_r_data, dac_r_valid,
        output dac_l_ready, dac_r_ready,
        input  dsp_start, dsp_l_in, dsp_r_in,
        output dsp_done, dsp_l_out, dsp_r_out
    );
endinterface

// File: rtl/audio_frame_sequencer.sv
// Per-frame L/R capture -> DSP (or bypass) -> DAC sequencer with mute and DSP watchdog.
// Define AUDIO_SEQ_STATS_EN to add the frame_cnt / tmo_cnt statistics ports.
module audio_frame_sequencer #(
    parameter int DW      = 24,
    parameter int TMO_CYC = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    audio_frame_sequencer_if.slave bus,
    input  logic                   mute,
    input  logic                   bypass,
    output logic                   busy,
    output logic                   tmo_err
`ifdef AUDIO_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic [CNT_W-1:0]       tmo_cnt
`endif
);
    localparam int             WD_W    = $clog2(TMO_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYC - 1);

    // BYP_LOAD is a one-cycle staging step so the bypassed pair loads from settled holding regs.
    typedef enum logic [1:0] {CAPTURE, PROCESS, BYP_LOAD, OUTPUT} state_t;

    state_t          state, state_nx;
    logic            run;
    logic            l_held, r_held;
    logic [DW-1:0]   l_hold, r_hold;
    logic [WD_W-1:0] wd_cnt;

    logic            l_xfer, r_xfer, pair_done;
    logic            dsp_ok, wd_exp;
    logic            l_owe, r_owe;
    logic            out_load, frame_end;
    logic [DW-1:0]   l_sel, r_sel;

    assign l_xfer    = bus.adc_l_valid & bus.adc_l_ready;
    assign r_xfer    = bus.adc_r_valid & bus.adc_r_ready;
    assign pair_done = (l_held | l_xfer) & (r_held | r_xfer);
    assign dsp_ok    = bus.dsp_done & (wd_cnt != '0);
    assign wd_exp    = (wd_cnt == WD_LAST);
    assign l_owe     = bus.dac_l_valid & ~bus.dac_l_ready;
    assign r_owe     = bus.dac_r_valid & ~bus.dac_r_ready;
    assign out_load  = (state != OUTPUT) && (state_nx == OUTPUT);
    assign frame_end = (state == OUTPUT) && (state_nx == CAPTURE);
    assign l_sel     = (state == PROCESS && dsp_ok) ? bus.dsp_l_out : l_hold;
    assign r_sel     = (state == PROCESS && dsp_ok) ? bus.dsp_r_out : r_hold;

    assign bus.dsp_l_in = l_hold;
    assign bus.dsp_r_in = r_hold;

    always_ff @(posedge clk) begin
        if (reset) state <= CAPTURE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            CAPTURE:  if (pair_done) state_nx = bypass ? BYP_LOAD : PROCESS;
            PROCESS:  if (dsp_ok || wd_exp) state_nx = OUTPUT;
            BYP_LOAD: state_nx = OUTPUT;
            OUTPUT:   if (!l_owe && !r_owe) state_nx = CAPTURE;
            default:  state_nx = CAPTURE;
        endcase
    end

    always_comb begin
        bus.adc_l_ready = 1'b0;
        bus.adc_r_ready = 1'b0;
        bus.dsp_start   = 1'b0;
        tmo_err         = 1'b0;
        busy            = 1'b1;
        case (state)
            CAPTURE: begin
                busy            = 1'b0;
                bus.adc_l_ready = run & ~l_held;
                bus.adc_r_ready = run & ~r_held;
            end
            PROCESS: begin
                bus.dsp_start = (wd_cnt == '0);
                tmo_err       = wd_exp & ~dsp_ok;
            end
            default: ;
        endcase
    end

    // run holds the ready outputs low for the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            run             <= 1'b0;
            l_held          <= 1'b0;
            r_held          <= 1'b0;
            l_hold          <= '0;
            r_hold          <= '0;
            wd_cnt          <= '0;
            bus.dac_l_data  <= '0;
            bus.dac_r_data  <= '0;
            bus.dac_l_valid <= 1'b0;
            bus.dac_r_valid <= 1'b0;
        end else begin
            run <= 1'b1;
            if (l_xfer) begin
                l_hold <= bus.adc_l_data;
                l_held <= 1'b1;
            end
            if (r_xfer) begin
                r_hold <= bus.adc_r_data;
                r_held <= 1'b1;
            end
            if (frame_end) begin
                l_held <= 1'b0;
                r_held <= 1'b0;
            end

            if (state == PROCESS) wd_cnt <= wd_exp ? wd_cnt : wd_cnt + WD_W'(1);
            else                  wd_cnt <= '0;

            if (out_load) begin
                bus.dac_l_data  <= mute ? '0 : l_sel;
                bus.dac_r_data  <= mute ? '0 : r_sel;
                bus.dac_l_valid <= 1'b1;
                bus.dac_r_valid <= 1'b1;
            end else begin
                if (bus.dac_l_valid && bus.dac_l_ready) bus.dac_l_valid <= 1'b0;
                if (bus.dac_r_valid && bus.dac_r_ready) bus.dac_r_valid <= 1'b0;
            end
        end
    end

`ifdef AUDIO_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            if (frame_end && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
            if (tmo_err && tmo_cnt != '1)     tmo_cnt   <= tmo_cnt + CNT_W'(1);
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Scoreboard bench for audio_frame_sequencer: expected DAC words queued at ADC drive time.
// Counter checks run when AUDIO_SEQ_STATS_EN is defined.
module tb_audio_frame_sequencer;
    localparam int DW    = 24;
    localparam int TMO   = 8;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset;
    logic mute, bypass;
    logic busy, tmo_err;
`ifdef AUDIO_SEQ_STATS_EN
    logic [CNT_W-1:0] frame_cnt, tmo_cnt;
`endif

    audio_frame_sequencer_if #(.DW(DW)) bus ();

    audio_frame_sequencer #(.DW(DW), .TMO_CYC(TMO), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mute      (mute),
        .bypass    (bypass),
        .busy      (busy),
        .tmo_err   (tmo_err)
`ifdef AUDIO_SEQ_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .tmo_cnt   (tmo_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int n_lpop = 0, n_rpop = 0, n_start = 0, n_tmo = 0;
    int start_cyc = 0, tmo_cyc = 0;
    int dsp_lat = 3;
    bit dsp_resp = 1'b1;
    logic [DW-1:0] cur_l = '0, cur_r = '0;
    logic [DW-1:0] q_l[$];
    logic [DW-1:0] q_r[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // DAC scoreboard and event monitor
    initial forever begin
        @(negedge clk);
        if (reset === 1'b0) begin
            if (bus.dsp_start === 1'b1) begin n_start++; start_cyc = cyc; end
            if (tmo_err === 1'b1)       begin n_tmo++;   tmo_cyc   = cyc; end
            if (bus.dac_l_valid === 1'b1 && bus.dac_l_ready === 1'b1) begin
                if (q_l.size() == 0) chk("dac_l_unexp", 32'(q_l.size()), 32'd1);
                else                 chk("dac_l", 32'(bus.dac_l_data), 32'(q_l.pop_front()));
                n_lpop++;
            end
            if (bus.dac_r_valid === 1'b1 && bus.dac_r_ready === 1'b1) begin
                if (q_r.size() == 0) chk("dac_r_unexp", 32'(q_r.size()), 32'd1);
                else                 chk("dac_r", 32'(bus.dac_r_data), 32'(q_r.pop_front()));
                n_rpop++;
            end
        end
    end

    // DSP model: returns in+1 dsp_lat cycles after the start cycle
    initial begin
        bus.dsp_done  = 1'b0;
        bus.dsp_l_out = '0;
        bus.dsp_r_out = '0;
        forever begin
            @(negedge clk);
            if (bus.dsp_start === 1'b1 && dsp_resp && reset === 1'b0) begin
                chk("dsp_in_l", 32'(bus.dsp_l_in), 32'(cur_l));
                chk("dsp_in_r", 32'(bus.dsp_r_in), 32'(cur_r));
                repeat (dsp_lat) @(posedge clk);
                #1;
                bus.dsp_done  = 1'b1;
                bus.dsp_l_out = bus.dsp_l_in + DW'(1);
                bus.dsp_r_out = bus.dsp_r_in + DW'(1);
                @(posedge clk); #1;
                bus.dsp_done  = 1'b0;
            end
        end
    end

    task automatic adc_send(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input logic [DW-1:0] el, input logic [DW-1:0] er, input bit track);
        bit got_l, got_r, tl, tr;
        int i;
        if (track) begin q_l.push_back(el); q_r.push_back(er); end
        cur_l = l; cur_r = r;
        bus.adc_l_data = l; bus.adc_l_valid = 1'b1;
        bus.adc_r_data = r; bus.adc_r_valid = 1'b1;
        got_l = 1'b0; got_r = 1'b0; i = 0;
        while (i < 300 && !(got_l && got_r)) begin
            @(negedge clk);
            tl = bus.adc_l_valid && bus.adc_l_ready;
            tr = bus.adc_r_valid && bus.adc_r_ready;
            @(posedge clk); #1;
            if (tl) begin got_l = 1'b1; bus.adc_l_valid = 1'b0; end
            if (tr) begin got_r = 1'b1; bus.adc_r_valid = 1'b0; end
            i++;
        end
        if (!(got_l && got_r)) chk("adc_send_tmo", 32'({got_l, got_r}), 32'd3);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (i < 300 && (busy || q_l.size() != 0 || q_r.size() != 0)) begin
            @(negedge clk);
            i++;
        end
        if (i >= 300) chk(tag, 32'(q_l.size() + q_r.size() + int'(busy)), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n0, nl0, nr0, bad;
        reset = 1'b1; mute = 1'b0; bypass = 1'b0;
        bus.adc_l_valid = 1'b0; bus.adc_l_data = '0;
        bus.adc_r_valid = 1'b0; bus.adc_r_data = '0;
        bus.dac_l_ready = 1'b1; bus.dac_r_ready = 1'b1;

        // reset state and ready lag
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_l_rdy",   32'(bus.adc_l_ready), 32'd0);
        chk("rst_r_rdy",   32'(bus.adc_r_ready), 32'd0);
        chk("rst_l_vld",   32'(bus.dac_l_valid), 32'd0);
        chk("rst_r_vld",   32'(bus.dac_r_valid), 32'd0);
        chk("rst_l_data",  32'(bus.dac_l_data), 32'd0);
        chk("rst_start",   32'(bus.dsp_start), 32'd0);
        chk("rst_tmo",     32'(tmo_err), 32'd0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("rdy_lag", 32'(bus.adc_l_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rdy_up_l", 32'(bus.adc_l_ready), 32'd1);
        chk("rdy_up_r", 32'(bus.adc_r_ready), 32'd1);
        @(posedge clk); #1;

        // bypass: same-cycle pair, DAC valid at T+2, no dsp_start
        bypass = 1'b1; n0 = n_start;
        adc_send(24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF, 1'b1);
        bypass = 1'b0;
        @(negedge clk);
        chk("byp_t1_vld", 32'(bus.dac_l_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("byp_t2_vld_l", 32'(bus.dac_l_valid), 32'd1);
        chk("byp_t2_vld_r", 32'(bus.dac_r_valid), 32'd1);
        wait_idle("byp_idle");
        chk("byp_no_start", 32'(n_start - n0), 32'd0);

        // staggered capture through the DSP path (latency 3)
        dsp_resp = 1'b1; dsp_lat = 3;
        cur_l = 24'h123456; cur_r = 24'hABCDEF;
        q_l.push_back(24'h123457); q_r.push_back(24'hABCDF0);
        bus.adc_l_data = 24'h123456; bus.adc_l_valid = 1'b1;
        @(negedge clk);
        chk("stg_l_rdy0", 32'(bus.adc_l_ready), 32'd1);
        @(posedge clk); #1;
        bus.adc_l_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) begin bus.adc_r_data = 24'hABCDEF; bus.adc_r_valid = 1'b1; end
            @(negedge clk);
            chk("stg_l_rdy", 32'(bus.adc_l_ready), 32'd0);
            chk("stg_start_early", 32'(bus.dsp_start), 32'd0);
            if (k == 4) chk("stg_r_rdy", 32'(bus.adc_r_ready), 32'd1);
            @(posedge clk); #1;
        end
        bus.adc_r_valid = 1'b0;
        @(negedge clk);
        chk("stg_start", 32'(bus.dsp_start), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stg_start_1cyc", 32'(bus.dsp_start), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("dsp_done_cyc_vld", 32'(bus.dac_l_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("dsp_d1_vld", 32'(bus.dac_l_valid), 32'd1);
        wait_idle("stg_idle");

        // watchdog: no done -> dry samples, tmo_err 7 cycles after start
        dsp_resp = 1'b0; n0 = n_tmo;
        adc_send(24'h111111, 24'h222222, 24'h111111, 24'h222222, 1'b1);
        wait_idle("wd_idle");
        chk("wd_tmo_cnt", 32'(n_tmo - n0), 32'd1);
        chk("wd_tmo_lat", 32'(tmo_cyc - start_cyc), 32'd7);

        // done on the expiry cycle wins
        dsp_resp = 1'b1; dsp_lat = 7; n0 = n_tmo;
        adc_send(24'h333333, 24'h444444, 24'h333334, 24'h444445, 1'b1);
        wait_idle("wd_edge_idle");
        chk("wd_edge_notmo", 32'(n_tmo - n0), 32'd0);

        // mute with right-channel backpressure
        mute = 1'b1; dsp_lat = 3; bus.dac_r_ready = 1'b0;
        nl0 = n_lpop; nr0 = n_rpop;
        adc_send(24'hAAAAAA, 24'h555555, 24'h000000, 24'h000000, 1'b1);
        n0 = 0;
        while (n0 < 50 && n_lpop == nl0) begin @(negedge clk); n0++; end
        chk("mute_l_xfer", 32'(n_lpop - nl0), 32'd1);
        @(posedge clk); #1;
        bus.adc_l_data = 24'h010203; bus.adc_l_valid = 1'b1;
        bus.adc_r_data = 24'h040506; bus.adc_r_valid = 1'b1;
        mute = 1'b0; bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!(bus.dac_r_valid === 1'b1 && bus.dac_r_data === '0 &&
                  bus.adc_l_ready === 1'b0 && bus.adc_r_ready === 1'b0)) bad++;
            @(posedge clk); #1;
        end
        chk("mute_r_hold", 32'(bad), 32'd0);
        chk("mute_r_npop", 32'(n_rpop - nr0), 32'd0);
        bus.dac_r_ready = 1'b1;
        adc_send(24'h010203, 24'h040506, 24'h010204, 24'h040507, 1'b1);
        wait_idle("mute_idle");

        // reset in PROCESS discards the frame
        dsp_resp = 1'b0;
        adc_send(24'h777777, 24'h888888, '0, '0, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmid_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.dac_l_valid !== 1'b0 || bus.dac_r_valid !== 1'b0) bad++;
        end
        chk("rmid_no_vld", 32'(bad), 32'd0);
        chk("rmid_idle", 32'(busy), 32'd0);
`ifdef AUDIO_SEQ_STATS_EN
        chk("rmid_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rmid_tmo_cnt",   32'(tmo_cnt), 32'd0);
`endif
        @(posedge clk); #1;

        // three frames, one timing out
        n0 = n_tmo;
        dsp_resp = 1'b1; dsp_lat = 2;
        adc_send(24'h00000A, 24'h00000B, 24'h00000B, 24'h00000C, 1'b1);
        wait_idle("f1_idle");
        dsp_resp = 1'b0;
        adc_send(24'hFFFFFF, 24'h800000, 24'hFFFFFF, 24'h800000, 1'b1);
        wait_idle("f2_idle");
        bypass = 1'b1;
        adc_send(24'h0F0F0F, 24'hF0F0F0, 24'h0F0F0F, 24'hF0F0F0, 1'b1);
        bypass = 1'b0;
        wait_idle("f3_idle");
        chk("f3_tmo", 32'(n_tmo - n0), 32'd1);
`ifdef AUDIO_SEQ_STATS_EN
        chk("stat_frame_cnt", 32'(frame_cnt), 32'd3);
        chk("stat_tmo_cnt",   32'(tmo_cnt), 32'd1);
`endif
        chk("end_q_empty", 32'(q_l.size() + q_r.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
